updi_baud_ctrl: RTL and testbench
=================================

UPDI_BAUD_CTRL -- requirements
Module: updi_baud_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, bit-period counter and divisor width.
REQ-002 SHALL have parameter DEFAULT_DIV, default 10, divisor after reset; legal range 2..2^CNT_W-1.
REQ-003 SHALL have port clk_in  input  1  clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port enable  input  1  level; 1 = run bit timing, 0 = idle.
REQ-006 SHALL have port div_in  input  CNT_W  requested clocks per bit.
REQ-007 SHALL have port div_load  input  1  pulse; request divisor change to div_in.
REQ-008 SHALL have port resync  input  1  pulse; realign bit phase (RX start edge).
REQ-009 SHALL have port wait_start  input  1  pulse; start guard/wait of wait_bits bit-times.
REQ-010 SHALL have port wait_bits  input  8  wait length in bit periods.
REQ-011 SHALL have port bit_tick  output  1  one-cycle pulse at each bit boundary.
REQ-012 SHALL have port mid_tick  output  1  one-cycle pulse at bit midpoint (sample point).
REQ-013 SHALL have port cfg_ack  output  1  one-cycle pulse when new divisor takes effect.
REQ-014 SHALL have port running  output  1  1 while in RUN state.
REQ-015 SHALL have port wait_busy  output  1  wait in progress.
REQ-016 SHALL have port wait_done  output  1  one-cycle pulse, wait completed.
REQ-017 SHALL have port div_active  output  CNT_W  divisor currently in use.

Function
REQ-018 SHALL implement states IDLE and RUN; IDLE->RUN on edge sampling enable=1, RUN->IDLE on edge sampling enable=0; running registered from state.
REQ-019 SHALL, on IDLE->RUN edge, set counter cnt to 0; in RUN, cnt counts 0..div_active-1 then wraps to 0 (wrap = edge where cnt==div_active-1).
REQ-020 SHALL assert bit_tick (registered) on the cycle after each wrap edge only; first bit_tick div_active cycles after entering RUN; period exactly div_active.
REQ-021 SHALL assert mid_tick (registered) after edge where cnt==(div_active>>1)-1 in RUN.
REQ-022 SHALL clamp any requested divisor <2 to 2 before use.
REQ-023 SHALL, on div_load in RUN, hold div_in as pending (later div_load overwrites pending) and apply it at the next wrap or resync, pulsing cfg_ack that cycle.
REQ-024 SHALL, on div_load coincident with a wrap, apply div_in directly at that wrap; bit_tick and cfg_ack coincide.
REQ-025 SHALL, on div_load in IDLE, apply immediately with cfg_ack next cycle.
REQ-026 SHALL, on resync in RUN, set cnt to 0, suppress bit_tick/mid_tick for that edge, apply pending divisor; resync beats simultaneous wrap; resync in IDLE ignored.
REQ-027 SHALL, on wait_start in RUN with wait_busy=0, set wait_busy and load remaining=wait_bits; each wrap decrements remaining.
REQ-028 SHALL assert wait_done and clear wait_busy coincident with the bit_tick where remaining reaches 0.
REQ-029 SHALL, for wait_bits=0, pulse wait_done next cycle without setting wait_busy.
REQ-030 SHALL ignore wait_start while wait_busy=1 or in IDLE.
REQ-031 SHALL, on RUN->IDLE, clear cnt, wait_busy, all pulses; aborted wait gives no wait_done; pending divisor kept.

Reset
REQ-032 SHALL, on rst, enter IDLE, cnt=0, pending cleared, div_active=DEFAULT_DIV, all other outputs 0; rst overrides all inputs, including mid-operation.

Verification
(Cycle k = outputs after k-th edge; edge 0 samples enable=1 from IDLE; DEFAULT_DIV=10.)
REQ-033 SHALL test free run: enable held -> bit_tick at 10,20,30; mid_tick at 5,15,25; running=1 from cycle 0.
REQ-034 SHALL test divisor change: div_load div_in=4 at edge 13 -> div_active=4 and cfg_ack+bit_tick at 20; bit_tick at 24,28.
REQ-035 SHALL test clamp: div_load div_in=1 in IDLE -> div_active=2, cfg_ack next cycle; RUN bit_tick every 2 cycles.
REQ-036 SHALL test resync: resync at edge 17 -> no bit_tick at 20; next bit_tick at 27, then 37.
REQ-037 SHALL test wait: wait_start wait_bits=3 at edge 2 -> wait_busy high cycles 2..29; wait_done+bit_tick at 30.
REQ-038 SHALL test abort/reset: enable=0 at edge 15 during 3-bit wait -> wait_busy 0 at 15, no wait_done; rst at any point -> div_active=10, outputs 0 next cycle.

Source files
------------

// File: rtl/updi_baud_ctrl.sv
// UPDI bit-timing generator: bit/mid ticks, glitch-free divisor changes, phase resync and bit-time waits.
// Ticks and acks are registered one cycle after the edge that causes them; no backpressure (pure pulses).
module updi_baud_ctrl #(
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 10
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             enable,
  input  logic [CNT_W-1:0] div_in,
  input  logic             div_load,
  input  logic             resync,
  input  logic             wait_start,
  input  logic [7:0]       wait_bits,
  output logic             bit_tick,
  output logic             mid_tick,
  output logic             cfg_ack,
  output logic             running,
  output logic             wait_busy,
  output logic             wait_done,
  output logic [CNT_W-1:0] div_active
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);
  localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] pend_div;
  logic             pend_vld;
  logic [7:0]       remaining;

  logic             wrap;
  logic             mid_hit;
  logic [CNT_W-1:0] div_req;

  function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] d);
    return (d < TWO) ? TWO : d;
  endfunction

  assign div_req = clamp_div(div_in);
  assign wrap    = (cnt == div_active - ONE);
  assign mid_hit = (cnt == (div_active >> 1) - ONE);

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      pend_div   <= '0;
      pend_vld   <= 1'b0;
      remaining  <= '0;
      div_active <= DEF_DIV;
      bit_tick   <= 1'b0;
      mid_tick   <= 1'b0;
      cfg_ack    <= 1'b0;
      running    <= 1'b0;
      wait_busy  <= 1'b0;
      wait_done  <= 1'b0;
    end else begin
      bit_tick  <= 1'b0;
      mid_tick  <= 1'b0;
      cfg_ack   <= 1'b0;
      wait_done <= 1'b0;

      case (state)
        IDLE: begin
          cnt       <= '0;
          wait_busy <= 1'b0;
          // No bit timing to protect: a fresh request supersedes any held one.
          if (div_load) begin
            div_active <= div_req;
            cfg_ack    <= 1'b1;
            pend_vld   <= 1'b0;
          end
          if (enable) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end

        RUN: begin
          if (!enable) begin
            // Leaving RUN aborts any wait silently but keeps a pending divisor.
            state     <= IDLE;
            running   <= 1'b0;
            cnt       <= '0;
            wait_busy <= 1'b0;
            if (div_load) begin
              pend_div <= div_req;
              pend_vld <= 1'b1;
            end
          end else begin
            if (resync || wrap) begin
              cnt <= '0;
              if (div_load) begin
                div_active <= div_req;
                cfg_ack    <= 1'b1;
                pend_vld   <= 1'b0;
              end else if (pend_vld) begin
                div_active <= pend_div;
                cfg_ack    <= 1'b1;
                pend_vld   <= 1'b0;
              end
            end else begin
              cnt <= cnt + ONE;
              if (div_load) begin
                pend_div <= div_req;
                pend_vld <= 1'b1;
              end
            end

            // Resync realigns the phase, so the boundary it lands on is not a real bit edge.
            if (!resync) begin
              bit_tick <= wrap;
              mid_tick <= mid_hit;
            end

            if (wait_busy) begin
              if (wrap && !resync) begin
                if (remaining == 8'd1) begin
                  wait_busy <= 1'b0;
                  wait_done <= 1'b1;
                  remaining <= '0;
                end else begin
                  remaining <= remaining - 8'd1;
                end
              end
            end else if (wait_start) begin
              remaining <= wait_bits;
              if (wait_bits == 8'd0) wait_done <= 1'b1;
              else                   wait_busy <= 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_updi_baud_ctrl.sv
// Directed bench for updi_baud_ctrl: cycle k means outputs sampled just after the k-th edge,
// with edge 0 the one that samples enable=1 from IDLE.
module tb_updi_baud_ctrl;

  logic        clk_in = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] div_in;
  logic        div_load;
  logic        resync;
  logic        wait_start;
  logic [7:0]  wait_bits;
  logic        bit_tick, mid_tick, cfg_ack, running, wait_busy, wait_done;
  logic [15:0] div_active;

  int total = 0;
  int bad   = 0;

  updi_baud_ctrl #(.CNT_W(16), .DEFAULT_DIV(10)) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .enable    (enable),
    .div_in    (div_in),
    .div_load  (div_load),
    .resync    (resync),
    .wait_start(wait_start),
    .wait_bits (wait_bits),
    .bit_tick  (bit_tick),
    .mid_tick  (mid_tick),
    .cfg_ack   (cfg_ack),
    .running   (running),
    .wait_busy (wait_busy),
    .wait_done (wait_done),
    .div_active(div_active)
  );

  always #5 clk_in = ~clk_in;

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d got=%0h want=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic clear_pulses();
    div_load   = 1'b0;
    resync     = 1'b0;
    wait_start = 1'b0;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    enable    = 1'b0;
    div_in    = '0;
    wait_bits = '0;
    clear_pulses();
    cyc();
    rst = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag, input int k);
    chk({tag, "_div"}, k, div_active, 32'd10);
    chk({tag, "_outs"}, k, {bit_tick, mid_tick, cfg_ack, running, wait_busy, wait_done}, 32'd0);
  endtask

  initial begin
    // Reset state
    do_reset();
    check_idle_outputs("rst", -1);

    // Free run at the default divisor
    enable = 1'b1;
    cyc();
    chk("run0_running", 0, running, 1);
    chk("run0_bit", 0, bit_tick, 0);
    for (int k = 1; k <= 32; k++) begin
      cyc();
      chk("free_bit", k, bit_tick, (k % 10 == 0));
      chk("free_mid", k, mid_tick, (k % 10 == 5));
      chk("free_running", k, running, 1);
    end

    // Divisor change requested mid-bit takes effect at the next boundary
    do_reset();
    enable = 1'b1;
    cyc();
    for (int k = 1; k <= 30; k++) begin
      div_load = (k == 13);
      div_in   = 16'd4;
      cyc();
      chk("chg_bit", k, bit_tick, (k == 10 || k == 20 || k == 24 || k == 28));
      chk("chg_ack", k, cfg_ack, (k == 20));
      chk("chg_div", k, div_active, (k >= 20) ? 32'd4 : 32'd10);
      chk("chg_mid", k, mid_tick, (k == 5 || k == 15 || k == 22 || k == 26 || k == 30));
    end
    clear_pulses();

    // Clamp: a divisor of 1 loaded in IDLE becomes 2 immediately
    do_reset();
    div_load = 1'b1;
    div_in   = 16'd1;
    cyc();
    chk("clamp_ack", 0, cfg_ack, 1);
    chk("clamp_div", 0, div_active, 2);
    div_load = 1'b0;
    cyc();
    chk("clamp_ack_drop", 0, cfg_ack, 0);
    enable = 1'b1;
    cyc();
    for (int k = 1; k <= 8; k++) begin
      cyc();
      chk("clamp_bit", k, bit_tick, (k % 2 == 0));
      chk("clamp_mid", k, mid_tick, (k % 2 == 1));
    end

    // Resync mid-bit realigns the phase and suppresses the old boundary
    do_reset();
    enable = 1'b1;
    cyc();
    for (int k = 1; k <= 40; k++) begin
      resync = (k == 17);
      cyc();
      chk("rsy_bit", k, bit_tick, (k == 10 || k == 27 || k == 37));
      chk("rsy_mid", k, mid_tick, (k == 5 || k == 15 || k == 22 || k == 32));
    end
    clear_pulses();

    // Resync coincident with a wrap wins and applies the pending divisor
    do_reset();
    enable = 1'b1;
    cyc();
    for (int k = 1; k <= 23; k++) begin
      div_load = (k == 3);
      div_in   = 16'd6;
      resync   = (k == 10);
      cyc();
      chk("rw_bit", k, bit_tick, (k == 16 || k == 22));
      chk("rw_ack", k, cfg_ack, (k == 10));
      chk("rw_div", k, div_active, (k >= 10) ? 32'd6 : 32'd10);
    end
    clear_pulses();

    // Bit-time wait; a second start while busy is ignored; zero-length wait
    do_reset();
    enable = 1'b1;
    cyc();
    for (int k = 1; k <= 34; k++) begin
      wait_start = (k == 2 || k == 5 || k == 33);
      wait_bits  = (k == 5) ? 8'd1 : ((k == 33) ? 8'd0 : 8'd3);
      cyc();
      chk("wait_busy", k, wait_busy, (k >= 2 && k <= 29));
      chk("wait_done", k, wait_done, (k == 30 || k == 33));
      chk("wait_bit", k, bit_tick, (k % 10 == 0));
    end
    clear_pulses();

    // Abort by dropping enable mid-wait; pending divisor survives IDLE
    do_reset();
    enable = 1'b1;
    cyc();
    for (int k = 1; k <= 52; k++) begin
      enable     = !(k >= 15 && k <= 35);
      wait_start = (k == 2 || k == 20);
      wait_bits  = (k == 20) ? 8'd0 : 8'd3;
      div_load   = (k == 12);
      div_in     = 16'd5;
      resync     = (k == 25);
      cyc();
      chk("ab_busy", k, wait_busy, (k >= 2 && k <= 14));
      chk("ab_done", k, wait_done, 0);
      chk("ab_running", k, running, (k < 15 || k >= 36));
      chk("ab_bit", k, bit_tick, (k == 10 || k == 46 || k == 51));
      chk("ab_ack", k, cfg_ack, (k == 46));
      chk("ab_div", k, div_active, (k >= 46) ? 32'd5 : 32'd10);
    end
    clear_pulses();

    // Reset mid-operation overrides enable
    rst = 1'b1;
    cyc();
    check_idle_outputs("rst_mid", 53);
    rst = 1'b0;
    enable = 1'b0;
    cyc();
    check_idle_outputs("post_rst", 54);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
